// File: rtl/dpll_lock_monitor.sv
// DPLL lock qualifier: judges each input period, drives hysteretic lock state, signal-loss and error stats.
// Outputs registered, 1 cycle after the edge; no backpressure. Define DPLL_LOCKMON_STATS_EN for Lead/Lag counters.
module dpll_lock_monitor #(
  parameter int GOOD_TO_LOCK   = 16,
  parameter int BAD_TO_UNLOCK  = 4,
  parameter int PERIOD_TOL     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        MainClock,
  input  logic        Reset,
  input  logic        InputSignalEdge,
  input  logic        Lead,
  input  logic        Lag,
  input  logic [7:0]  PeriodCount,
  output logic        LockQualified,
  output logic [1:0]  LockState,
  output logic        SignalLoss,
  output logic [7:0]  PhaseErrorCount,
  output logic [15:0] LeadCount,
  output logic [15:0] LagCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACQUIRE  = 2'b01,
    LOCKED   = 2'b10,
    HOLDOVER = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] prev_period;
  logic [7:0] good_cnt;
  logic [7:0] bad_cnt;
  logic [7:0] gap_cnt;
  logic       err_seen;

  logic [8:0] period_diff;
  logic       err_win;
  logic       good;
  logic       timeout;

  always_comb begin
    period_diff = ({1'b0, PeriodCount} >= {1'b0, prev_period}) ?
                  ({1'b0, PeriodCount} - {1'b0, prev_period}) :
                  ({1'b0, prev_period} - {1'b0, PeriodCount});
    // an error pulse in the closing edge cycle still belongs to the window being judged
    err_win = err_seen | Lead | Lag;
    good    = !err_win && (period_diff <= 9'(PERIOD_TOL));
    timeout = !InputSignalEdge && (state != IDLE) && (gap_cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  assign LockState = state;

  always_ff @(posedge MainClock) begin
    if (Reset) begin
      state         <= IDLE;
      LockQualified <= 1'b0;
      SignalLoss    <= 1'b0;
      prev_period   <= 8'd0;
      good_cnt      <= 8'd0;
      bad_cnt       <= 8'd0;
      gap_cnt       <= 8'd0;
      err_seen      <= 1'b0;
    end else begin
      if (InputSignalEdge) begin
        gap_cnt     <= 8'd0;
        err_seen    <= 1'b0;
        prev_period <= PeriodCount;
      end else begin
        if (gap_cnt != 8'hFF)
          gap_cnt <= gap_cnt + 8'd1;
        err_seen <= err_win;
      end

      if (timeout) begin
        state         <= IDLE;
        SignalLoss    <= 1'b1;
        LockQualified <= 1'b0;
      end else if (InputSignalEdge) begin
        case (state)
          IDLE: begin
            state         <= ACQUIRE;
            good_cnt      <= 8'd0;
            bad_cnt       <= 8'd0;
            SignalLoss    <= 1'b0;
            LockQualified <= 1'b0;
          end
          ACQUIRE: begin
            if (!good) begin
              good_cnt <= 8'd0;
            end else if (good_cnt + 8'd1 == 8'(GOOD_TO_LOCK)) begin
              state         <= LOCKED;
              LockQualified <= 1'b1;
              bad_cnt       <= 8'd0;
            end else begin
              good_cnt <= good_cnt + 8'd1;
            end
          end
          LOCKED: begin
            if (!good) begin
              if (BAD_TO_UNLOCK == 1) begin
                state         <= ACQUIRE;
                LockQualified <= 1'b0;
                good_cnt      <= 8'd0;
              end else begin
                state   <= HOLDOVER;
                bad_cnt <= 8'd1;
              end
            end
          end
          HOLDOVER: begin
            if (good) begin
              state   <= LOCKED;
              bad_cnt <= 8'd0;
            end else if (bad_cnt + 8'd1 == 8'(BAD_TO_UNLOCK)) begin
              state         <= ACQUIRE;
              LockQualified <= 1'b0;
              good_cnt      <= 8'd0;
            end else begin
              bad_cnt <= bad_cnt + 8'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge MainClock) begin
    if (Reset)
      PhaseErrorCount <= 8'd0;
    else if ((Lead | Lag) && PhaseErrorCount != 8'hFF)
      PhaseErrorCount <= PhaseErrorCount + 8'd1;
  end

`ifdef DPLL_LOCKMON_STATS_EN
  always_ff @(posedge MainClock) begin
    if (Reset) begin
      LeadCount <= 16'd0;
      LagCount  <= 16'd0;
    end else begin
      if (Lead && LeadCount != 16'hFFFF)
        LeadCount <= LeadCount + 16'd1;
      if (Lag && LagCount != 16'hFFFF)
        LagCount <= LagCount + 16'd1;
    end
  end
`else
  assign LeadCount = 16'd0;
  assign LagCount  = 16'd0;
`endif

endmodule

// File: tb/tb_dpll_lock_monitor.sv
// Bench for dpll_lock_monitor: directed scenarios plus randomized windows, every cycle checked
// against a streak/timestamp reference model.
module tb_dpll_lock_monitor;

  localparam int G_LOCK  = 16;
  localparam int B_UNLK  = 4;
  localparam int TOL     = 2;
  localparam int TMO     = 255;
  localparam int S_IDLE  = 0;
  localparam int S_ACQ   = 1;
  localparam int S_LOCK  = 2;
  localparam int S_HOLD  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        edge_in = 1'b0;
  logic        lead = 1'b0;
  logic        lag = 1'b0;
  logic [7:0]  period = 8'd0;
  logic        lock_q;
  logic [1:0]  lock_state;
  logic        sig_loss;
  logic [7:0]  perr_cnt;
  logic [15:0] lead_cnt;
  logic [15:0] lag_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dpll_lock_monitor #(
    .GOOD_TO_LOCK(G_LOCK), .BAD_TO_UNLOCK(B_UNLK),
    .PERIOD_TOL(TOL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .MainClock(clk), .Reset(rst), .InputSignalEdge(edge_in), .Lead(lead), .Lag(lag),
    .PeriodCount(period), .LockQualified(lock_q), .LockState(lock_state),
    .SignalLoss(sig_loss), .PhaseErrorCount(perr_cnt), .LeadCount(lead_cnt), .LagCount(lag_cnt)
  );

  always #5 clk = ~clk;

  // reference model: state after every clock edge seen so far
  int     m_state, m_good, m_bad, m_prev, m_perr, m_lead, m_lag;
  bit     m_loss;
  longint cyc, last_edge, last_err;

  task automatic chk_val(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit ld, input bit lg, input int pc);
    bit dirty, ok;
    int d;
    cyc++;
    if (r) begin
      m_state = S_IDLE; m_good = 0; m_bad = 0; m_prev = 0; m_loss = 0;
      m_perr = 0; m_lead = 0; m_lag = 0;
      last_edge = cyc; last_err = cyc;
      return;
    end
    dirty = (last_err > last_edge) || ld || lg;
    if (ld || lg) begin
      last_err = cyc;
      if (m_perr < 255) m_perr++;
    end
    if (ld && m_lead < 65535) m_lead++;
    if (lg && m_lag < 65535) m_lag++;
    if (!e) begin
      if (m_state != S_IDLE && (cyc - last_edge) >= TMO) begin
        m_state = S_IDLE;
        m_loss  = 1;
      end
      return;
    end
    d  = pc - m_prev;
    if (d < 0) d = -d;
    ok = !dirty && (d <= TOL);
    case (m_state)
      S_IDLE: begin m_state = S_ACQ; m_loss = 0; m_good = 0; m_bad = 0; end
      S_ACQ: begin
        if (ok) begin
          m_good++;
          if (m_good >= G_LOCK) m_state = S_LOCK;
        end else m_good = 0;
      end
      S_LOCK: begin
        if (!ok) begin
          if (B_UNLK == 1) begin m_state = S_ACQ; m_good = 0; end
          else begin m_state = S_HOLD; m_bad = 1; end
        end
      end
      default: begin
        if (ok) begin m_state = S_LOCK; m_bad = 0; end
        else begin
          m_bad++;
          if (m_bad >= B_UNLK) begin m_state = S_ACQ; m_good = 0; end
        end
      end
    endcase
    m_prev    = pc;
    last_edge = cyc;
  endtask

  task automatic drive(input bit r, input bit e, input bit ld, input bit lg, input int pc);
    rst = r; edge_in = e; lead = ld; lag = lg; period = pc[7:0];
    model_step(r, e, ld, lg, pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_val("state", lock_state, m_state);
    chk_val("lockq", lock_q, (m_state >= S_LOCK) ? 1 : 0);
    chk_val("loss", sig_loss, m_loss);
    chk_val("perr", perr_cnt, m_perr);
`ifdef DPLL_LOCKMON_STATS_EN
    chk_val("leadcnt", lead_cnt, m_lead);
    chk_val("lagcnt", lag_cnt, m_lag);
`else
    chk_val("leadcnt", lead_cnt, 0);
    chk_val("lagcnt", lag_cnt, 0);
`endif
  endtask

  // len cycles, edge on the last one; lead/lag pulses at given offsets (-1 = none)
  task automatic window(input int len, input int pc, input int lead_pos, input int lag_pos);
    for (int i = 0; i < len; i++) begin
      drive(0, i == len - 1, i == lead_pos, i == lag_pos, (i == len - 1) ? pc : 0);
      tick();
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic acquire_lock();
    for (int i = 0; i < G_LOCK + 1; i++) window(40, 40, -1, -1);
  endtask

  initial begin
    cyc = 0;
    drive(1, 0, 0, 0, 0);
    tick();
    chk_val("rst_state", lock_state, 0);
    chk_val("rst_loss", sig_loss, 0);
    chk_val("rst_perr", perr_cnt, 0);
    do_reset(1);

    // lock acquisition at 40-cycle periods
    window(40, 40, -1, -1);
    chk_val("acq_e1_state", lock_state, 1);
    for (int i = 0; i < G_LOCK - 1; i++) window(40, 40, -1, -1);
    chk_val("acq_e16_state", lock_state, 1);
    chk_val("acq_e16_lockq", lock_q, 0);
    window(40, 40, -1, -1);
    chk_val("acq_e17_state", lock_state, 2);
    chk_val("acq_e17_lockq", lock_q, 1);

    // single lead pulse -> holdover, clean window -> locked
    window(40, 40, 20, -1);
    chk_val("hold_state", lock_state, 3);
    chk_val("hold_lockq", lock_q, 1);
    window(40, 40, -1, -1);
    chk_val("relock_state", lock_state, 2);
    // lag in the closing edge cycle counts against that window
    window(40, 40, -1, 39);
    chk_val("edgecyc_err_state", lock_state, 3);
    window(40, 40, -1, -1);
    chk_val("edgecyc_relock", lock_state, 2);

    // alternating periods drop lock after BAD_TO_UNLOCK bad edges
    window(40, 45, -1, -1);
    chk_val("alt_e1", lock_state, 3);
    window(40, 40, -1, -1);
    chk_val("alt_e2", lock_state, 3);
    window(40, 45, -1, -1);
    chk_val("alt_e3", lock_state, 3);
    window(40, 40, -1, -1);
    chk_val("alt_e4", lock_state, 1);
    chk_val("alt_e4_lockq", lock_q, 0);

    // tolerance boundary
    acquire_lock();
    window(42, 42, -1, -1);
    chk_val("tol_plus2", lock_state, 2);
    window(40, 40, -1, -1);
    chk_val("tol_minus2", lock_state, 2);
    window(43, 43, -1, -1);
    chk_val("tol_plus3", lock_state, 3);

    // signal loss timing
    window(40, 43, -1, -1);
    chk_val("pre_loss_state", lock_state, 2);
    quiet(TMO - 1);
    chk_val("loss_early", sig_loss, 0);
    quiet(1);
    chk_val("loss_set", sig_loss, 1);
    chk_val("loss_state", lock_state, 0);
    chk_val("loss_lockq", lock_q, 0);
    window(40, 40, -1, -1);
    chk_val("loss_clear", sig_loss, 0);
    chk_val("loss_reacq", lock_state, 1);
    acquire_lock();
    window(TMO, 40, -1, -1);
    chk_val("tmo_edge_loss", sig_loss, 0);
    chk_val("tmo_edge_state", lock_state, 2);

    // reset mid-lock
    do_reset(3);
    chk_val("midrst_state", lock_state, 0);
    chk_val("midrst_lockq", lock_q, 0);
    chk_val("midrst_perr", perr_cnt, 0);

    // error statistics saturation
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 1, (i == 100) || (i == 200), 0);
      tick();
    end
    chk_val("stat_perr", perr_cnt, 255);
`ifdef DPLL_LOCKMON_STATS_EN
    chk_val("stat_lead", lead_cnt, 300);
    chk_val("stat_lag", lag_cnt, 2);
`else
    chk_val("stat_lead", lead_cnt, 0);
    chk_val("stat_lag", lag_cnt, 0);
`endif
    do_reset(1);

    // randomized windows
    for (int w = 0; w < 400; w++) begin
      int len, pc;
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(250, 262) : $urandom_range(4, 60);
      pc  = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 255) : 40 + $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        bit r, e, ld, lg;
        r  = ($urandom_range(0, 2999) == 0);
        e  = (i == len - 1);
        ld = ($urandom_range(0, 599) == 0);
        lg = ($urandom_range(0, 599) == 0);
        drive(r, e, ld, lg, e ? pc : $urandom_range(0, 255));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
